// File: rtl/lcd_pkg.sv
// Shared constants, init ROM, state encodings and timing helper for the
// HD44780-style character LCD writer.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h38;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  localparam int unsigned INIT_LEN = 6;

  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    FUNC_SET, FUNC_SET, FUNC_SET, DISP_ON, CLEAR, ENTRY
  };

  // DDRAM start address of each display row
  localparam logic [6:0] ROW_BASE [4] = '{7'h00, 7'h40, 7'h10, 7'h50};

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT,
    IDLE,
    SET_ADDR,
    WR_DATA,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_E_HIGH,
    TX_HOLD,
    TX_WAIT
  } tx_phase_e;

  // Microseconds to clock cycles, rounded up, never below one cycle.
  function automatic int unsigned us_to_cyc(input longint unsigned us,
                                            input longint unsigned clk_hz);
    longint unsigned c;
    c = (us * clk_hz + 64'd999_999) / 64'd1_000_000;
    return (c == 64'd0) ? 32'd1 : 32'(c);
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One LCD bus write: SETUP (1 cycle), E high (E_HIGH_CYC), HOLD (1 cycle),
// then a post-write wait of wait_cyc cycles. fin marks the last wait cycle.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int unsigned E_HIGH_CYC = 1,
  parameter int unsigned WAIT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rs,
  input  logic [7:0]        data_in,
  input  logic [WAIT_W-1:0] wait_cyc,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic [7:0]        lcd_data,
  output logic              fin
);

  localparam int unsigned EW = (E_HIGH_CYC > 1) ? $clog2(E_HIGH_CYC) : 1;

  tx_phase_e         phase_q, phase_d;
  logic [EW-1:0]     e_cnt_q, e_cnt_d;
  logic [WAIT_W-1:0] w_cnt_q, w_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              e_q, e_d;
  logic              rs_q, rs_d;
  logic [7:0]        data_q, data_d;

  assign fin      = (phase_q == TX_WAIT) && (w_cnt_q == '0);
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

  always_comb begin
    // NOTE: every signal takes its hold value first, so no branch can leave it
    // unassigned and infer a latch.
    phase_d = phase_q;
    e_cnt_d = e_cnt_q;
    w_cnt_d = w_cnt_q;
    wait_d  = wait_q;
    e_d     = e_q;
    rs_d    = rs_q;
    data_d  = data_q;

    case (phase_q)
      TX_IDLE: ;
      TX_SETUP: begin
        phase_d = TX_E_HIGH;
        e_d     = 1'b1;
        e_cnt_d = EW'(E_HIGH_CYC - 1);
      end
      TX_E_HIGH: begin
        if (e_cnt_q == '0) begin
          phase_d = TX_HOLD;
          e_d     = 1'b0;
        end else begin
          e_cnt_d = e_cnt_q - EW'(1);
        end
      end
      TX_HOLD: begin
        phase_d = TX_WAIT;
        w_cnt_d = wait_q - WAIT_W'(1);
      end
      TX_WAIT: begin
        if (w_cnt_q == '0) phase_d = TX_IDLE;
        else               w_cnt_d = w_cnt_q - WAIT_W'(1);
      end
      default: phase_d = TX_IDLE;
    endcase

    // A start on the final wait cycle chains the next byte with no idle gap.
    if (start && ((phase_q == TX_IDLE) || fin)) begin
      phase_d = TX_SETUP;
      rs_d    = rs;
      data_d  = data_in;
      wait_d  = wait_cyc;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= TX_IDLE;
      e_cnt_q <= '0;
      w_cnt_q <= '0;
      wait_q  <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      phase_q <= phase_d;
      e_cnt_q <= e_cnt_d;
      w_cnt_q <= w_cnt_d;
      wait_q  <= wait_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// Character LCD writer: power-up init, then (row, col, char) requests become
// set-DDRAM-address + data writes. Option: LCD_ADDR_CACHE_EN skips redundant addressing.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000,
  parameter int unsigned ROWS         = 2,
  parameter int unsigned E_HIGH_CYC   = 1,
  parameter int unsigned INIT_WAIT_US = 15000,
  parameter int unsigned CMD_WAIT_US  = 40,
  parameter int unsigned CLR_WAIT_US  = 1640
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_req,
  input  logic [1:0] lcd_row,
  input  logic [3:0] lcd_col,
  input  logic [7:0] lcd_char,
  output logic       lcd_busy,
  output logic       lcd_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned INIT_CYC = us_to_cyc(64'(INIT_WAIT_US), 64'(CLK_HZ));
  localparam int unsigned CMD_CYC  = us_to_cyc(64'(CMD_WAIT_US), 64'(CLK_HZ));
  localparam int unsigned CLR_CYC  = us_to_cyc(64'(CLR_WAIT_US), 64'(CLK_HZ));
  localparam int unsigned WAIT_MAX = (CLR_CYC > CMD_CYC) ? CLR_CYC : CMD_CYC;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int unsigned PW_W     = $clog2(INIT_CYC + 1);
  localparam logic [2:0]  LAST_IDX = 3'(INIT_LEN - 1);

  state_e            state_q, state_d;
  logic [PW_W-1:0]   pw_cnt_q, pw_cnt_d;
  logic [2:0]        init_idx_q, init_idx_d;
  logic              rearm_q, rearm_d;
  logic [6:0]        addr_q, addr_d;
  logic [7:0]        char_q, char_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tx_start;
  logic              tx_rs;
  logic [7:0]        tx_byte;
  logic [WAIT_W-1:0] tx_wait;
  logic              tx_fin;

  logic [1:0]        row_eff;
  logic [6:0]        req_addr;
  logic [2:0]        nxt_idx;
  logic              accept;
  logic              cache_hit;

  // On a two-row panel the upper row bit carries no meaning.
  assign row_eff  = (ROWS == 2) ? {1'b0, lcd_row[0]} : lcd_row;
  assign req_addr = ROW_BASE[row_eff] + {3'b000, lcd_col};
  assign nxt_idx  = init_idx_q + 3'd1;
  assign accept   = lcd_req && rearm_q;

  // Only the clear-display command needs the long settle time.
  assign tx_wait = (!tx_rs && (tx_byte == CLEAR)) ? WAIT_W'(CLR_CYC) : WAIT_W'(CMD_CYC);

`ifdef LCD_ADDR_CACHE_EN
  logic [6:0] cache_addr_q, cache_addr_d;
  logic       cache_valid_q, cache_valid_d;

  assign cache_hit = cache_valid_q && (cache_addr_q == req_addr);

  // Mirrors the controller's auto-incrementing DDRAM address counter.
  always_comb begin
    cache_addr_d  = cache_addr_q;
    cache_valid_d = cache_valid_q;
    if ((state_q == INIT) && tx_fin) begin
      if (INIT_ROM[init_idx_q] == CLEAR) cache_addr_d  = 7'h00;
      if (init_idx_q == LAST_IDX)        cache_valid_d = 1'b1;
    end
    if ((state_q == IDLE) && accept && !cache_hit) cache_addr_d = req_addr;
    if ((state_q == WR_DATA) && tx_fin)            cache_addr_d = addr_q + 7'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_addr_q  <= 7'h00;
      cache_valid_q <= 1'b0;
    end else begin
      cache_addr_q  <= cache_addr_d;
      cache_valid_q <= cache_valid_d;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pw_cnt_d   = pw_cnt_q;
    init_idx_d = init_idx_q;
    rearm_d    = rearm_q;
    addr_d     = addr_q;
    char_d     = char_q;
    tx_start   = 1'b0;
    tx_rs      = 1'b0;
    tx_byte    = INIT_ROM[0];

    if (!lcd_req) rearm_d = 1'b1;

    case (state_q)
      PWR_WAIT: begin
        if (pw_cnt_q == PW_W'(INIT_CYC - 1)) begin
          tx_start   = 1'b1;
          init_idx_d = 3'd0;
          state_d    = INIT;
        end else begin
          pw_cnt_d = pw_cnt_q + PW_W'(1);
        end
      end
      INIT: begin
        if (tx_fin) begin
          if (init_idx_q == LAST_IDX) begin
            state_d = IDLE;
            rearm_d = 1'b1;
          end else begin
            init_idx_d = nxt_idx;
            tx_start   = 1'b1;
            tx_byte    = INIT_ROM[nxt_idx];
          end
        end
      end
      IDLE: begin
        if (accept) begin
          rearm_d  = 1'b0;
          addr_d   = req_addr;
          char_d   = lcd_char;
          tx_start = 1'b1;
          if (cache_hit) begin
            tx_rs   = 1'b1;
            tx_byte = lcd_char;
            state_d = WR_DATA;
          end else begin
            tx_byte = SET_DDRAM | {1'b0, req_addr};
            state_d = SET_ADDR;
          end
        end
      end
      SET_ADDR: begin
        if (tx_fin) begin
          tx_start = 1'b1;
          tx_rs    = 1'b1;
          tx_byte  = char_q;
          state_d  = WR_DATA;
        end
      end
      WR_DATA: begin
        if (tx_fin) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = PWR_WAIT;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWR_WAIT;
      pw_cnt_q   <= '0;
      init_idx_q <= 3'd0;
      rearm_q    <= 1'b0;
      addr_q     <= 7'h00;
      char_q     <= 8'h00;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_cnt_q   <= pw_cnt_d;
      init_idx_q <= init_idx_d;
      rearm_q    <= rearm_d;
      addr_q     <= addr_d;
      char_q     <= char_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  lcd_byte_tx #(
    .E_HIGH_CYC (E_HIGH_CYC),
    .WAIT_W     (WAIT_W)
  ) u_byte_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tx_start),
    .rs       (tx_rs),
    .data_in  (tx_byte),
    .wait_cyc (tx_wait),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data),
    .fin      (tx_fin)
  );

  assign lcd_busy = busy_q;
  assign lcd_done = done_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Scoreboard bench for lcd_char_writer: a request-level model queues the
// expected bus bytes, and a monitor checks each E strobe against the queue.
module tb_lcd_char_writer;

  localparam int TB_ROWS = 2;
`ifdef LCD_ADDR_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif
  localparam logic [7:0] INIT_SEQ [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_req = 1'b0;
  logic [1:0] lcd_row = 2'd0;
  logic [3:0] lcd_col = 4'd0;
  logic [7:0] lcd_char = 8'h00;
  logic       lcd_busy, lcd_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  lcd_char_writer #(
    .CLK_HZ       (100_000),
    .ROWS         (TB_ROWS),
    .E_HIGH_CYC   (1),
    .INIT_WAIT_US (15000),
    .CMD_WAIT_US  (40),
    .CLR_WAIT_US  (1640)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_req  (lcd_req),
    .lcd_row  (lcd_row),
    .lcd_col  (lcd_col),
    .lcd_char (lcd_char),
    .lcd_busy (lcd_busy),
    .lcd_done (lcd_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         e_rises = 0;
  int         done_cnt = 0;
  int         rise_log[$];
  logic [8:0] exp_q[$];
  logic       e_prev = 1'b0;
  bit         m_valid = 1'b0;
  int         m_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rising E strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      e_rises++;
      rise_log.push_back(cyc);
      check("rw_low", lcd_rw, 0);
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("sb_byte", {lcd_rs, lcd_data}, exp_q.pop_front());
    end
    if (lcd_done) begin
      done_cnt++;
      check("done_busy_low", lcd_busy, 0);
    end
    e_prev <= lcd_e;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: display address arithmetic and bus bytes per request.
  function automatic int row_base(input int row);
    int r;
    r = (TB_ROWS == 2) ? row % 2 : row;
    return (r % 2) * 'h40 + (r / 2) * 'h10;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, INIT_SEQ[i]});
    m_valid = 1'b1;
    m_addr  = 0;
  endtask

  task automatic model_req(input int row, input int col, input logic [7:0] ch,
                           output int n_bytes);
    int a;
    bit hit;
    a   = row_base(row) + col;
    hit = CACHE_EN && m_valid && (a == m_addr);
    n_bytes = 0;
    if (!hit) begin
      exp_q.push_back({1'b0, 8'(8'h80 + a)});
      n_bytes++;
    end
    exp_q.push_back({1'b1, ch});
    n_bytes++;
    m_addr = (a + 1) % 128;
  endtask

  task automatic wait_busy_low(input int budget, input string name);
    int n;
    n = 0;
    while (lcd_busy && n < budget) begin
      tick();
      n++;
    end
    if (lcd_busy) check(name, lcd_busy, 0);
  endtask

  // Called on the first busy cycle of a transaction; runs it to completion.
  task automatic finish_service(input int e0, input int d0, input int n_bytes);
    int n;
    n = 0;
    while (lcd_busy && n < 60) begin
      tick();
      n++;
    end
    check("busy_cycles", n, 7 * n_bytes);
    check("done_pulse", lcd_done, 1);
    tick();
    check("done_one_cycle", lcd_done, 0);
    check("done_count", done_cnt - d0, 1);
    check("strobe_count", e_rises - e0, n_bytes);
  endtask

  task automatic do_request(input int row, input int col, input logic [7:0] ch,
                            output int n_bytes);
    int e0, d0, n;
    model_req(row, col, ch, n_bytes);
    e0 = e_rises;
    d0 = done_cnt;
    lcd_row  = 2'(row);
    lcd_col  = 4'(col);
    lcd_char = ch;
    lcd_req  = 1'b1;
    n = 0;
    while (!lcd_busy && n < 5) begin
      tick();
      n++;
    end
    check("accept_latency", n, 1);
    // Inputs after acceptance must not disturb the transaction.
    lcd_row  = 2'($urandom);
    lcd_col  = 4'($urandom);
    lcd_char = 8'($urandom);
    finish_service(e0, d0, n_bytes);
  endtask

  initial begin
    int nb, e0, d0, n, t0, fall;
    int prev_r, prev_c;
    bit busy_seen;

    // Reset values
    tick();
    check("rst_busy", lcd_busy, 1);
    check("rst_done", lcd_done, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_e", lcd_e, 0);
    check("rst_data", lcd_data, 8'h00);

    // Power-up init sequence
    model_init();
    rise_log.delete();
    t0 = cyc;
    rst_n = 1'b1;
    wait_busy_low(3000, "init_timeout");
    fall = cyc;
    check("init_strobes", e_rises, 6);
    check("init_sb_empty", exp_q.size(), 0);
    check("init_rise_log", rise_log.size(), 6);
    if (rise_log.size() == 6) begin
      check("first_e_delay", (rise_log[0] - t0) inside {[1500:1510]}, 1);
      check("clear_gap", (rise_log[5] - rise_log[4]) >= 166, 1);
      check("busy_after_last_wait", (fall - rise_log[5]) >= 6, 1);
    end

    // Directed request, then req held high must not retrigger
    do_request(1, 3, 8'h41, nb);
    e0 = e_rises;
    busy_seen = 1'b0;
    repeat (100) begin
      tick();
      if (lcd_busy) busy_seen = 1'b1;
    end
    check("hold_no_strobe", e_rises - e0, 0);
    check("hold_no_busy", busy_seen, 0);
    lcd_req = 1'b0;
    tick();
    do_request(2, 9, 8'h5B, nb);
    lcd_req = 1'b0;
    tick();

    // Consecutive columns on one row
    do_request(1, 3, 8'h41, nb);
    lcd_req = 1'b0;
    tick();
    e0 = e_rises;
    do_request(1, 4, 8'h42, nb);
    check("seq_col_strobes", e_rises - e0, CACHE_EN ? 1 : 2);
    lcd_req = 1'b0;
    tick();

    // Randomised requests, often continuing on the next column
    prev_r = 1;
    prev_c = 4;
    for (int i = 0; i < 40; i++) begin
      int r, c;
      logic [7:0] ch;
      if ($urandom_range(0, 1) == 1) begin
        r = prev_r;
        c = (prev_c + 1) % 16;
      end else begin
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 15);
      end
      ch = 8'($urandom);
      do_request(r, c, ch, nb);
      prev_r = r;
      prev_c = c;
      lcd_req = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    // Reset while the data byte is on the bus
    model_req(3, 2, 8'h7E, nb);
    e0 = e_rises;
    d0 = done_cnt;
    lcd_row  = 2'd3;
    lcd_col  = 4'd2;
    lcd_char = 8'h7E;
    lcd_req  = 1'b1;
    n = 0;
    while (e_rises < e0 + nb && n < 40) begin
      tick();
      n++;
    end
    check("reach_wr_data", e_rises - e0, nb);
    rst_n = 1'b0;
    #1;
    check("midrst_e_low", lcd_e, 0);
    check("midrst_busy_high", lcd_busy, 1);
    check("midrst_data_zero", lcd_data, 8'h00);
    lcd_req = 1'b0;
    tick();
    tick();
    check("midrst_no_done", done_cnt - d0, 0);

    // Init replays; a request raised during INIT is served right after
    exp_q.delete();
    m_valid = 1'b0;
    model_init();
    model_req(0, 5, 8'h5A, nb);
    e0 = e_rises;
    lcd_row  = 2'd0;
    lcd_col  = 4'd5;
    lcd_char = 8'h5A;
    rst_n = 1'b1;
    repeat (1600) tick();
    lcd_req = 1'b1;
    wait_busy_low(3000, "reinit_timeout");
    check("reinit_strobes", e_rises - e0, 6);
    e0 = e_rises;
    d0 = done_cnt;
    n = 0;
    while (!lcd_busy && n < 5) begin
      tick();
      n++;
    end
    check("held_req_accept", n, 1);
    finish_service(e0, d0, nb);
    lcd_req = 1'b0;
    repeat (5) tick();
    check("final_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not complete, %0d tests run", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
